// File: rtl/layer_sequencer.sv
// Layer scheduler for the CNN accelerator: waits for the initial data, then walks the
// conv/pool/fc layer table one start/ready handshake at a time. Optional watchdog: LAYER_TIMEOUT_EN.
module layer_sequencer #(
    parameter int LAYER_NUM_WIDTH = 3,
    parameter int NUM_LAYERS      = 5
`ifdef LAYER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_WIDTH   = 20
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       transmission_start,
    input  logic                       init_fm_data_done,
    input  logic                       weight_data_done,
    input  logic                       layer_ready,
    output logic                       init,
    output logic                       layer_start,
    output logic [LAYER_NUM_WIDTH-1:0] layer_num,
    output logic [1:0]                 layer_type,
    output logic [1:0]                 pre_layer_type,
    output logic                       busy,
    output logic                       net_done,
    output logic                       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_LOAD      = 3'd2,
        S_START     = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam logic [LAYER_NUM_WIDTH-1:0] LAST_LAYER = LAYER_NUM_WIDTH'(NUM_LAYERS - 1);

    // Network layer table: 0 prepare, 1 conv, 2 pool, 3 fc.
    function automatic logic [1:0] type_of(input logic [LAYER_NUM_WIDTH-1:0] n);
        logic [1:0] t;
        case (n)
            LAYER_NUM_WIDTH'(1): t = 2'd1;
            LAYER_NUM_WIDTH'(2): t = 2'd1;
            LAYER_NUM_WIDTH'(3): t = 2'd2;
            LAYER_NUM_WIDTH'(4): t = 2'd3;
            default:             t = 2'd0;
        endcase
        return t;
    endfunction

    state_t                     state_q, state_d;
    logic                       trans_start_q, trans_start_d;
    logic                       init_q, init_d;
    logic                       layer_start_q, layer_start_d;
    logic                       net_done_q, net_done_d;
    logic                       busy_q, busy_d;
    logic [LAYER_NUM_WIDTH-1:0] layer_num_q, layer_num_d;
    logic [1:0]                 layer_type_q, layer_type_d;
    logic [1:0]                 pre_type_q, pre_type_d;
    logic                       trigger_s;

`ifdef LAYER_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                     timeout_err_q, timeout_err_d;
`endif

    assign trigger_s = transmission_start & ~trans_start_q;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d       = state_q;
        trans_start_d = transmission_start;
        init_d        = 1'b0;
        layer_start_d = 1'b0;
        net_done_d    = 1'b0;
        busy_d        = busy_q;
        layer_num_d   = layer_num_q;
        layer_type_d  = type_of(layer_num_q);
        pre_type_d    = pre_type_q;
`ifdef LAYER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (trigger_s) begin
                    init_d       = 1'b1;
                    busy_d       = 1'b1;
                    layer_num_d  = {LAYER_NUM_WIDTH{1'b0}};
                    layer_type_d = 2'd0;
                    pre_type_d   = 2'd0;
                    state_d      = S_WAIT_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (init_fm_data_done && weight_data_done) begin
                    pre_type_d  = 2'd0;
                    layer_num_d = LAYER_NUM_WIDTH'(1);
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            // layer_type settles on this edge, so the start pulse lands with valid parameters.
            S_LOAD: begin
                layer_start_d = 1'b1;
                state_d       = S_START;
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (layer_ready) begin
                    pre_type_d = layer_type_q;
                    if (layer_num_q == LAST_LAYER) begin
                        net_done_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        layer_num_d = layer_num_q + LAYER_NUM_WIDTH'(1);
                        state_d     = S_LOAD;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
`ifdef LAYER_TIMEOUT_EN
        // Counter runs only while staying in a wait state; any transition restarts it from zero.
        if ((state_q == S_WAIT_DATA || state_q == S_RUN) && state_d == state_q) begin
            if (tmo_cnt_q == TMO_LAST) begin
                timeout_err_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
                tmo_cnt_d     = {TIMEOUT_WIDTH{1'b0}};
            end else begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
            end
        end else begin
            tmo_cnt_d = {TIMEOUT_WIDTH{1'b0}};
        end
`endif
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            trans_start_q <= 1'b0;
            init_q        <= 1'b0;
            layer_start_q <= 1'b0;
            net_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            layer_num_q   <= {LAYER_NUM_WIDTH{1'b0}};
            layer_type_q  <= 2'd0;
            pre_type_q    <= 2'd0;
`ifdef LAYER_TIMEOUT_EN
            tmo_cnt_q     <= {TIMEOUT_WIDTH{1'b0}};
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            trans_start_q <= trans_start_d;
            init_q        <= init_d;
            layer_start_q <= layer_start_d;
            net_done_q    <= net_done_d;
            busy_q        <= busy_d;
            layer_num_q   <= layer_num_d;
            layer_type_q  <= layer_type_d;
            pre_type_q    <= pre_type_d;
`ifdef LAYER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign init           = init_q;
    assign layer_start    = layer_start_q;
    assign net_done       = net_done_q;
    assign busy           = busy_q;
    assign layer_num      = layer_num_q;
    assign layer_type     = layer_type_q;
    assign pre_layer_type = pre_type_q;
`ifdef LAYER_TIMEOUT_EN
    assign timeout_err    = timeout_err_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule
